// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, header field positions, widths,
// FSM state encoding and the header flit builder.
package noc_pkg;

  localparam int FLIT_W  = 32;
  localparam int COORD_W = 2;
  localparam int CNT_W   = 3;
  localparam int LEN_W   = 4;
  localparam int SEQ_W   = 8;
  localparam int DATA_W  = 30;

  localparam logic [1:0] FLIT_HEAD = 2'b00;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  // Header field LSB positions (type occupies [31:30])
  localparam int TYPE_LSB  = 30;
  localparam int SRC_X_LSB = 28;
  localparam int SRC_Y_LSB = 26;
  localparam int DST_X_LSB = 24;
  localparam int DST_Y_LSB = 22;
  localparam int LEN_LSB   = 18;
  localparam int SEQ_LSB   = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_TAIL = 2'd3
  } pkt_state_e;

  // Assemble a header flit; bits [9:0] stay zero
  function automatic logic [FLIT_W-1:0] build_header(
    input logic [COORD_W-1:0] src_x,
    input logic [COORD_W-1:0] src_y,
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y,
    input logic [LEN_W-1:0]   len,
    input logic [SEQ_W-1:0]   seq
  );
    logic [FLIT_W-1:0] flit;
    flit = '0;
    flit[TYPE_LSB  +: 2]       = FLIT_HEAD;
    flit[SRC_X_LSB +: COORD_W] = src_x;
    flit[SRC_Y_LSB +: COORD_W] = src_y;
    flit[DST_X_LSB +: COORD_W] = dst_x;
    flit[DST_Y_LSB +: COORD_W] = dst_y;
    flit[LEN_LSB   +: LEN_W]   = len;
    flit[SEQ_LSB   +: SEQ_W]   = seq;
    return flit;
  endfunction

endpackage

// File: rtl/noc_credit_gate.sv
// Credit gate: a flit may be registered only when the router FIFO occupancy
// plus the flit currently on the wire (not yet counted) is below the depth.
module noc_credit_gate
  import noc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             enable,
  input  logic [CNT_W-1:0] count_out_local,
  input  logic             push_local,
  output logic             can_push
);

  localparam logic [CNT_W:0] DEPTH_L = FIFO_DEPTH[CNT_W:0];

  logic [CNT_W:0] inflight_s;

  // Occupancy plus in-flight push compared against FIFO depth
  always_comb begin
    inflight_s = {1'b0, count_out_local} + {{CNT_W{1'b0}}, push_local};
    can_push   = enable & (inflight_s < DEPTH_L);
  end

endmodule

// File: rtl/noc_packetizer.sv
// Injection-side network interface: turns a descriptor plus len+1 data words
// into a header/body/tail flit stream for the router local port.
// Optional build macro NOC_PKT_STATS_EN adds pkt_count / flit_count outputs.
module noc_packetizer
  import noc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BODY   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [COORD_W-1:0] routeridx,
  input  logic [COORD_W-1:0] routeridy,
  input  logic               msg_valid,
  output logic               msg_ready,
  input  logic [COORD_W-1:0] msg_dst_x,
  input  logic [COORD_W-1:0] msg_dst_y,
  input  logic [LEN_W-1:0]   msg_len,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [DATA_W-1:0]  data_in,
  output logic [FLIT_W-1:0]  local_in,
  output logic               push_local,
  input  logic [CNT_W-1:0]   count_out_local
`ifdef NOC_PKT_STATS_EN
  ,
  output logic [15:0]        pkt_count,
  output logic [15:0]        flit_count
`endif
);

  localparam logic [LEN_W-1:0] MAX_LEN = MAX_BODY[LEN_W-1:0];

  pkt_state_e          state_r;
  pkt_state_e          state_s;
  logic [COORD_W-1:0]  dst_x_r;
  logic [COORD_W-1:0]  dst_y_r;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W-1:0]    body_cnt_r;
  logic [SEQ_W-1:0]    seq_r;
  logic [LEN_W-1:0]    len_in_s;
  logic                can_push_s;
  logic                push_s;
  logic [FLIT_W-1:0]   flit_s;

  noc_credit_gate #(.FIFO_DEPTH(FIFO_DEPTH)) u_credit_gate (
    .enable          (enable),
    .count_out_local (count_out_local),
    .push_local      (push_local),
    .can_push        (can_push_s)
  );

  assign len_in_s = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: advance only on accepted descriptor or registered flit
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (msg_valid && msg_ready) state_s = ST_HEAD;
        else                        state_s = ST_IDLE;
      end
      ST_HEAD: begin
        if (push_s) state_s = (len_r == {LEN_W{1'b0}}) ? ST_TAIL : ST_BODY;
        else        state_s = ST_HEAD;
      end
      ST_BODY: begin
        if (push_s && (body_cnt_r == {{(LEN_W-1){1'b0}}, 1'b1})) state_s = ST_TAIL;
        else                                                     state_s = ST_BODY;
      end
      ST_TAIL: begin
        if (push_s) state_s = ST_IDLE;
        else        state_s = ST_TAIL;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake readies, push decision and flit to register
  always_comb begin
    msg_ready  = 1'b0;
    data_ready = 1'b0;
    push_s     = 1'b0;
    flit_s     = local_in;
    case (state_r)
      ST_IDLE: msg_ready = enable & ~reset;
      ST_HEAD: begin
        push_s = can_push_s;
        flit_s = build_header(routeridx, routeridy, dst_x_r, dst_y_r, len_r, seq_r);
      end
      ST_BODY: begin
        data_ready = can_push_s;
        push_s     = can_push_s & data_valid;
        flit_s     = {FLIT_BODY, data_in};
      end
      ST_TAIL: begin
        data_ready = can_push_s;
        push_s     = can_push_s & data_valid;
        flit_s     = {FLIT_TAIL, data_in};
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // Datapath: latch descriptor, register flits, track body count and sequence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      local_in   <= {FLIT_W{1'b0}};
      push_local <= 1'b0;
      dst_x_r    <= {COORD_W{1'b0}};
      dst_y_r    <= {COORD_W{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      body_cnt_r <= {LEN_W{1'b0}};
      seq_r      <= {SEQ_W{1'b0}};
    end else begin
      push_local <= push_s;
      if (push_s) begin
        local_in <= flit_s;
      end
      if (msg_valid && msg_ready) begin
        dst_x_r <= msg_dst_x;
        dst_y_r <= msg_dst_y;
        len_r   <= len_in_s;
      end
      if (push_s && (state_r == ST_HEAD)) begin
        body_cnt_r <= len_r;
        seq_r      <= seq_r + 8'd1;
      end else if (push_s && (state_r == ST_BODY)) begin
        body_cnt_r <= body_cnt_r - 4'd1;
      end
    end
  end

`ifdef NOC_PKT_STATS_EN
  // Statistics: flits and completed packets pushed, 16-bit wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count  <= 16'd0;
      flit_count <= 16'd0;
    end else begin
      if (push_s) begin
        flit_count <= flit_count + 16'd1;
      end
      if (push_s && (state_r == ST_TAIL)) begin
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_packetizer.sv
// Scoreboard bench for noc_packetizer: a driver issues descriptors and data,
// pushing the expected flit sequence into a queue; a monitor pops and compares
// on every push_local. A router FIFO model supplies count_out_local.
module tb_noc_packetizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  routeridx, routeridy;
  logic        msg_valid;
  logic        msg_ready;
  logic [1:0]  msg_dst_x, msg_dst_y;
  logic [3:0]  msg_len;
  logic        data_valid;
  logic        data_ready;
  logic [29:0] data_in;
  logic [31:0] local_in;
  logic        push_local;
  logic [2:0]  count_out_local;
`ifdef NOC_PKT_STATS_EN
  logic [15:0] pkt_count, flit_count;
`endif

  int cmp_n = 0;
  int err_n = 0;
  logic [31:0] exp_q[$];
  int push_cycles[$];
  int cyc = 0;
  int occ = 0;
  int pop_pct = 100;
  bit en_rand = 1'b0;
  int seq_m = 0;
  int pkt_m = 0;
  int flit_m = 0;

  noc_packetizer #(.FIFO_DEPTH(4), .MAX_BODY(15)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .routeridx       (routeridx),
    .routeridy       (routeridy),
    .msg_valid       (msg_valid),
    .msg_ready       (msg_ready),
    .msg_dst_x       (msg_dst_x),
    .msg_dst_y       (msg_dst_y),
    .msg_len         (msg_len),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .data_in         (data_in),
    .local_in        (local_in),
    .push_local      (push_local),
    .count_out_local (count_out_local)
`ifdef NOC_PKT_STATS_EN
    ,
    .pkt_count       (pkt_count),
    .flit_count      (flit_count)
`endif
  );

  always #5 clk = ~clk;

  assign count_out_local = occ[2:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Router FIFO model: enqueue on push_local, random pop, overflow check
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      occ <= 0;
    end else begin
      automatic int pop = ((occ > 0) && ($urandom_range(0, 99) < pop_pct)) ? 1 : 0;
      automatic int nxt = occ + (push_local ? 1 : 0) - pop;
      if (push_local) chk("fifo_overflow", (nxt > 4) ? 32'd1 : 32'd0, 32'd0);
      occ <= nxt;
    end
  end

  // Monitor: every pushed flit must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && push_local) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_flit", local_in, 32'hxxxx_xxxx);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        chk("flit", local_in, e);
      end
      push_cycles.push_back(cyc);
    end
  end

  // Enable driver plus freeze check: no push may follow a disabled cycle
  always @(negedge clk) begin
    if (!reset && !enable) chk("enable_freeze_push", {31'd0, push_local}, 32'd0);
    if (en_rand) enable = ($urandom_range(0, 9) != 0);
    else         enable = 1'b1;
  end

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // dv_pct < 0 toggles data_valid every cycle; abort_at > 0 resets after that many data handshakes
  task automatic send_msg(input logic [1:0] dx, input logic [1:0] dy, input logic [3:0] len,
                          input int dv_pct, input int abort_at, input bit directed);
    logic [29:0] w[16];
    int i, t;
    for (int k = 0; k < 16; k++) w[k] = 30'($urandom);
    if (directed) begin
      w[0] = 30'h15;
      exp_q.push_back(32'h0140_0000);
      exp_q.push_back(32'hC000_0015);
    end else begin
      exp_q.push_back({2'b00, routeridx, routeridy, dx, dy, len, 8'(seq_m), 10'd0});
      for (int k = 0; k < int'(len); k++) exp_q.push_back({2'b10, w[k]});
      exp_q.push_back({2'b11, w[len]});
    end
    seq_m++;
    pkt_m++;
    flit_m += int'(len) + 2;

    @(negedge clk);
    msg_valid = 1'b1; msg_dst_x = dx; msg_dst_y = dy; msg_len = len;
    t = 0;
    forever begin
      #1;
      if (msg_ready) begin
        @(posedge clk);
        break;
      end
      t++;
      if (t > 2000) begin
        chk("msg_handshake_timeout", 32'd1, 32'd0);
        msg_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(negedge clk);
    msg_valid = 1'b0;
    i = 0; t = 0;
    while (i <= int'(len)) begin
      if (dv_pct < 0) data_valid = ~data_valid;
      else            data_valid = ($urandom_range(0, 99) < dv_pct);
      data_in = w[i];
      #1;
      if (data_valid && data_ready) begin
        @(posedge clk);
        i++;
        if (abort_at == i) begin
          @(negedge clk);
          #2;
          reset = 1'b1;
          data_valid = 1'b0;
          exp_q.delete();
          #1;
          chk("abort_local_in", local_in, 32'd0);
          chk("abort_push_local", {31'd0, push_local}, 32'd0);
          chk("abort_msg_ready", {31'd0, msg_ready}, 32'd0);
          chk("abort_data_ready", {31'd0, data_ready}, 32'd0);
          @(negedge clk);
          reset = 1'b0;
          seq_m = 0; pkt_m = 0; flit_m = 0;
          return;
        end
      end
      t++;
      if (t > 4000) begin
        chk("data_handshake_timeout", 32'd1, 32'd0);
        data_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; enable = 1'b1;
    routeridx = 2'd0; routeridy = 2'd0;
    msg_valid = 1'b0; msg_dst_x = 2'd0; msg_dst_y = 2'd0; msg_len = 4'd0;
    data_valid = 1'b0; data_in = 30'd0;
    repeat (3) @(negedge clk);
    chk("reset_local_in", local_in, 32'd0);
    chk("reset_push_local", {31'd0, push_local}, 32'd0);
    chk("reset_msg_ready", {31'd0, msg_ready}, 32'd0);
    chk("reset_data_ready", {31'd0, data_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_msg_ready", {31'd0, msg_ready}, 32'd1);

    // 1: directed len 0 header/tail values
    send_msg(2'd1, 2'd1, 4'd0, 100, 0, 1'b1);
    drain();

    // 2: len 3 back-to-back flits with free credit
    routeridx = 2'd2; routeridy = 2'd1;
    send_msg(2'd3, 2'd0, 4'd3, 100, 0, 1'b0);
    drain();
    n = push_cycles.size();
    chk("t2_consecutive_span", push_cycles[n-1] - push_cycles[n-5], 32'd4);

    // 3: router stops popping; FIFO fills, pushes stall, then resume
    pop_pct = 0;
    fork
      begin
        repeat (40) @(negedge clk);
        chk("t3_fifo_full_count", {29'd0, count_out_local}, 32'd4);
        chk("t3_stalled_push", {31'd0, push_local}, 32'd0);
        pop_pct = 60;
      end
    join_none
    send_msg(2'd0, 2'd3, 4'd10, 100, 0, 1'b0);
    drain();

    // 4: data_valid toggling creates bubbles
    pop_pct = 100;
    send_msg(2'd1, 2'd2, 4'd2, -1, 0, 1'b0);
    drain();

    // 5: reset during body of len 5, then restart with seq 0
    send_msg(2'd2, 2'd2, 4'd5, 100, 2, 1'b0);
    repeat (2) @(negedge clk);

    // 6: two back-to-back messages, seq 0 then 1
    send_msg(2'd3, 2'd3, 4'd1, 100, 0, 1'b0);
    send_msg(2'd0, 2'd1, 4'd4, 100, 0, 1'b0);
    drain();
`ifdef NOC_PKT_STATS_EN
    chk("t6_pkt_count", {16'd0, pkt_count}, 32'd2);
    chk("t6_flit_count", {16'd0, flit_count}, 32'(flit_m));
`endif

    // Randomized traffic: enable drops, random credit, random data gaps
    en_rand = 1'b1;
    pop_pct = 50;
    for (int m = 0; m < 20; m++) begin
      routeridx = 2'($urandom); routeridy = 2'($urandom);
      send_msg(2'($urandom), 2'($urandom), 4'($urandom_range(0, 15)), 70, 0, 1'b0);
    end
    en_rand = 1'b0;
    drain();
`ifdef NOC_PKT_STATS_EN
    chk("final_pkt_count", {16'd0, pkt_count}, 32'(pkt_m));
    chk("final_flit_count", {16'd0, flit_count}, 32'(flit_m));
`endif
    chk("final_seq_count_of_pushes", push_cycles.size() > 0 ? 32'd1 : 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
